// File: rtl/branch_flag_unit.sv
// Branch resolution unit: latches ALU {Z,N} status and resolves conditional
// branches, jumps and branch-and-link ops. Returns the next PC and issues a link-register write.
module branch_flag_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flag_we,
  input  logic [1:0]      status_in,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_op,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_target,
  output logic            res_valid,
  output logic            res_taken,
  output logic [XLEN-1:0] next_pc,
  output logic            res_err,
  output logic            link_we,
  output logic [XLEN-1:0] link_data,
  output logic [1:0]      flags_q
);

  typedef enum logic [1:0] {IDLE, EVAL, LINK} state_t;

  localparam logic [2:0] OP_BZ   = 3'b000;
  localparam logic [2:0] OP_BNZ  = 3'b001;
  localparam logic [2:0] OP_BN   = 3'b010;
  localparam logic [2:0] OP_BNN  = 3'b011;
  localparam logic [2:0] OP_BALN = 3'b100;
  localparam logic [2:0] OP_JAL  = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;

  state_t state;

  logic            accept;
  logic [1:0]      snap_p0;
  logic            taken_p0;
  logic            err_p0;
  logic            link_p0;
  logic [XLEN-1:0] ret_p0;
  logic            link_p1;
  logic [XLEN-1:0] ret_p1;

  // zn = {Z, N}
  function automatic logic cond_taken(input logic [2:0] op, input logic [1:0] zn);
    case (op)
      OP_BZ:   return zn[1];
      OP_BNZ:  return !zn[1];
      OP_BN:   return zn[0];
      OP_BNN:  return !zn[0];
      OP_BALN: return zn[0];
      OP_JAL:  return 1'b1;
      OP_J:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Modulo 2^XLEN: the carry out of the top bit is simply discarded.
  function automatic logic [XLEN-1:0] ret_addr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  assign br_ready = (state == IDLE);
  assign accept   = br_valid & br_ready;

  // Stage p0: decode the request against forwarded flags in the accept cycle
  assign snap_p0  = flag_we ? status_in : flags_q;
  assign taken_p0 = cond_taken(br_op, snap_p0);
  assign err_p0   = (br_op == 3'b111);
  assign link_p0  = (br_op == OP_JAL) | ((br_op == OP_BALN) & taken_p0);
  assign ret_p0   = ret_addr(br_pc);

  // Stage p1: request capture; only meaningful while the FSM is out of IDLE
  always_ff @(posedge clk) begin
    if (accept) begin
      ret_p1  <= ret_p0;
      link_p1 <= link_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flags_q   <= 2'b00;
      res_valid <= 1'b0;
      res_taken <= 1'b0;
      res_err   <= 1'b0;
      next_pc   <= '0;
      link_we   <= 1'b0;
      link_data <= '0;
    end else begin
      if (flag_we) flags_q <= status_in;
      res_valid <= 1'b0;
      link_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= EVAL;
            res_valid <= 1'b1;
            res_taken <= taken_p0;
            res_err   <= err_p0;
            next_pc   <= taken_p0 ? br_target : ret_p0;
          end
        end
        EVAL: begin
          if (link_p1) begin
            state     <= LINK;
            link_we   <= 1'b1;
            link_data <= ret_p1;
          end else begin
            state <= IDLE;
          end
        end
        LINK:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
